// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result signal bundle for the iterative multiply/divide unit
//
// Purpose: groups the launch, abort, MTHI/MTLO and result signals of mul_div_unit.
// Ports (signals):
//   start_i, op_i, a_i, b_i   launch an operation (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   abort_i                   cancel in-flight work
//   mthi_i, mtlo_i, mt_data_i direct HI/LO writes
//   busy_o, done_o            status; done_o is a one-cycle pulse with valid hi_o/lo_o
//   hi_o, lo_o                HI/LO result registers
// Modports: master drives requests (pipeline side), slave is the unit itself.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             abort_i;
  logic             mthi_i;
  logic             mtlo_i;
  logic [WIDTH-1:0] mt_data_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, abort_i, mthi_i, mtlo_i, mt_data_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, abort_i, mthi_i, mtlo_i, mt_data_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
//
// Purpose: one result bit per cycle. Signed operations work on magnitudes and fix the
// result signs in a final FIX cycle. HI/LO are written on the FIX->DONE edge, on a
// divide-by-zero accept, or by MTHI/MTLO while the unit is not busy.
// Ports:
//   clk_i   clock, all state on the rising edge
//   rst_i   synchronous active-high reset
//   bus     mul_div_unit_if.slave: start_i/op_i/a_i/b_i, abort_i, mthi_i/mtlo_i/mt_data_i,
//           busy_o, done_o, hi_o, lo_o
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mul_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;   // product sign (multiply) or quotient sign (divide)
  logic               neg_r;   // remainder sign, follows the dividend
  logic [WIDTH-1:0]   opb;     // multiplicand magnitude, or divisor magnitude
  logic [2*WIDTH-1:0] acc;     // multiply: {partial product, remaining multiplier bits}
  logic [WIDTH-1:0]   rem;     // divide: partial remainder
  logic [WIDTH-1:0]   dq;      // divide: dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               busy, can_start, accept, div_zero, result_wr;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, remd, res_hi, res_lo;

  assign busy      = (state == CALC) || (state == FIX);
  assign can_start = (state == IDLE) || (state == DONE);
  assign accept    = can_start && bus.start_i && !bus.abort_i;
  assign div_zero  = bus.op_i[1] && (bus.b_i == '0);
  assign result_wr = (state == FIX) && !bus.abort_i;

  // op_i[0] set means unsigned, so sign bits only count for MULT/DIV.
  assign a_neg = !bus.op_i[0] && bus.a_i[WIDTH-1];
  assign b_neg = !bus.op_i[0] && bus.b_i[WIDTH-1];
  assign a_mag = a_neg ? -bus.a_i : bus.a_i;
  assign b_mag = b_neg ? -bus.b_i : bus.b_i;

  // Shift-add step: add the multiplicand when the current multiplier bit is set.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

  // Restoring step: the shifted remainder needs WIDTH+1 bits; once the divisor has been
  // subtracted the result is below the divisor again and fits WIDTH bits.
  assign div_shift = {rem, dq[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb};
  assign div_diff  = div_shift[WIDTH-1:0] - opb;

  assign prod   = neg_q ? -acc : acc;
  assign quot   = neg_q ? -dq : dq;
  assign remd   = neg_r ? -rem : rem;
  assign res_hi = is_div ? remd : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? quot : prod[WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = div_zero ? DONE : CALC;
        else        state_nxt = IDLE;
      end
      CALC: begin
        if (bus.abort_i)      state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = FIX;
      end
      FIX:     state_nxt = bus.abort_i ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      rem    <= '0;
      dq     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= '0;
        is_div <= bus.op_i[1];
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        opb    <= bus.op_i[1] ? b_mag : a_mag;
        acc    <= {{WIDTH{1'b0}}, b_mag};
        rem    <= '0;
        dq     <= a_mag;
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
        if (is_div) begin
          rem <= div_ge ? div_diff : div_shift[WIDTH-1:0];
          dq  <= {dq[WIDTH-2:0], div_ge};
        end else begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
        end
      end
    end
  end

  // Result writes take priority over MTHI/MTLO in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (result_wr) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (accept && div_zero) begin
      hi_q <= bus.a_i;
      lo_q <= '1;
    end else if (!busy) begin
      if (bus.mthi_i) hi_q <= bus.mt_data_i;
      if (bus.mtlo_i) lo_q <= bus.mt_data_i;
    end
  end

  assign bus.busy_o = busy;
  assign bus.done_o = (state == DONE);
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) bus ();
  mul_div_unit #(.WIDTH(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_hl = '0;  // bench's expected {hi, lo}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: begin qv = sa * sb; return qv; end
      2'b01: begin qv = ua * ub; return qv; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin q = sa / sb; r = sa % sb; qv = q; rv = r; end
        else begin qv = ua / ub; rv = ua % ub; end
        return {rv[31:0], qv[31:0]};
      end
    endcase
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_i = op;
    bus.a_i = a;
    bus.b_i = b;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.a_i = $urandom;  // operands must only matter in the accept cycle
    bus.b_i = $urandom;
  endtask

  // Called at T+1; returns cycles to done_o and number of busy cycles seen before it.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 1;
    nbusy = 0;
    while (bus.done_o !== 1'b1 && lat < 60) begin
      if (bus.busy_o === 1'b1) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int lat, nbusy, exp_lat;
    exp_lat = (op[1] && b == 32'd0) ? 1 : 34;
    launch(op, a, b);
    wait_done(lat, nbusy);
    exp_hl = model(op, a, b);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
    check({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, exp_hl);
  endtask

  initial begin
    int lat, nbusy, ndone;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    bus.start_i = 0; bus.op_i = 0; bus.a_i = 0; bus.b_i = 0; bus.abort_i = 0;
    bus.mthi_i = 0; bus.mtlo_i = 0; bus.mt_data_i = 0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {bus.busy_o, bus.done_o, bus.hi_o, bus.lo_o}, '0);
    rst = 1'b0;
    tick();

    // MULT -3 * 5
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg_const", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);

    // MULTU max*max, then DIV -7/2 launched in the DONE cycle
    tick();
    check("done_pulse_once", {bus.done_o, bus.busy_o}, 64'd0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_const", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFE_0000_0001);
    run_op("div_b2b", 2'b10, 32'hFFFF_FFF9, 32'd2);
    check("div_b2b_const", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);

    // divide by zero and signed overflow
    run_op("divu_zero", 2'b11, 32'd7, 32'd0);
    check("divu_zero_const", {bus.hi_o, bus.lo_o}, 64'h0000_0007_FFFF_FFFF);
    run_op("div_zero", 2'b10, 32'h8000_0005, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", {bus.hi_o, bus.lo_o}, 64'h0000_0000_8000_0000);

    // DIVU 100/7 aborted at T+10, with an ignored start at T+5
    tick();
    launch(2'b11, 32'd100, 32'd7);
    repeat (4) tick();
    bus.op_i = 2'b00; bus.a_i = 32'd3; bus.b_i = 32'd3; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("start_while_busy", 64'(bus.busy_o), 64'd1);
    repeat (4) tick();
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    check("abort_busy_done", {bus.busy_o, bus.done_o}, 64'd0);
    ndone = 0;
    repeat (40) begin
      if (bus.done_o === 1'b1) ndone++;
      tick();
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_hilo_kept", {bus.hi_o, bus.lo_o}, exp_hl);

    // MTHI while busy is ignored; in IDLE it writes HI only
    launch(2'b00, 32'd9, 32'd11);
    bus.mthi_i = 1'b1; bus.mtlo_i = 1'b1; bus.mt_data_i = 32'h1234;
    tick();
    bus.mthi_i = 1'b0; bus.mtlo_i = 1'b0;
    wait_done(lat, nbusy);
    exp_hl = model(2'b00, 32'd9, 32'd11);
    check("mt_busy_ignored", {bus.hi_o, bus.lo_o}, exp_hl);
    tick();
    bus.mthi_i = 1'b1; bus.mt_data_i = 32'h1234;
    tick();
    bus.mthi_i = 1'b0;
    exp_hl[63:32] = 32'h1234;
    check("mthi_idle", {bus.hi_o, bus.lo_o}, exp_hl);
    bus.mtlo_i = 1'b1; bus.mt_data_i = 32'hCAFE_0001;
    tick();
    bus.mtlo_i = 1'b0;
    exp_hl[31:0] = 32'hCAFE_0001;
    check("mtlo_idle", {bus.hi_o, bus.lo_o}, exp_hl);
    bus.mthi_i = 1'b1; bus.mtlo_i = 1'b1; bus.mt_data_i = 32'h5A5A_A5A5;
    tick();
    bus.mthi_i = 1'b0; bus.mtlo_i = 1'b0;
    exp_hl = {2{32'h5A5A_A5A5}};
    check("mt_both", {bus.hi_o, bus.lo_o}, exp_hl);

    // abort together with start in DONE: done already shown, start dropped
    run_op("divu_done_abort", 2'b11, 32'd100, 32'd7);
    bus.abort_i = 1'b1; bus.start_i = 1'b1; bus.op_i = 2'b01;
    tick();
    bus.abort_i = 1'b0; bus.start_i = 1'b0;
    check("abort_start_dropped", {bus.busy_o, bus.done_o}, 64'd0);
    check("abort_done_results", {bus.hi_o, bus.lo_o}, 64'h0000_0002_0000_000E);

    // reset in the middle of a MULT
    launch(2'b00, 32'h1234_5678, 32'h0FED_CBA9);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midop_reset", {bus.busy_o, bus.done_o, bus.hi_o, bus.lo_o}, '0);
    run_op("mult_6x7", 2'b00, 32'd6, 32'd7);
    check("mult_6x7_const", {bus.hi_o, bus.lo_o}, 64'd42);

    // randomized operations, alternately back-to-back and through IDLE
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
      if (i[0]) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
